// File: rtl/mux_8to1_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux among eight requesters.
// Grants one requester at a time, drives the mux selects to its index,
// releases on done / request drop / hold expiry, then waits a turnaround gap.
module mux_8to1_rr_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Last counter values before leaving GRANT / GAP.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [1:0] GAP_LAST  = 2'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t     state;
  logic [2:0] last;
  logic [2:0] sel;
  logic [3:0] cnt;
  logic [1:0] gap_cnt;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       grant_end;

  // Selects come straight from a register so they never glitch.
  assign {s2, s1, s0} = sel;

  // Any one of the release conditions ends the grant; they collapse into one release.
  assign grant_end = done || !req[last] || (cnt == HOLD_LAST);

  // Round-robin search: first set request starting one past the last grantee.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = last;
    for (int i = 1; i <= 8; i++) begin
      cand = last + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end else begin
        win_found = win_found;
      end
    end
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 8'h00;
      sel     <= 3'd0;
      busy    <= 1'b0;
      last    <= 3'd7;
      cnt     <= 4'd0;
      gap_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt   <= 8'h01 << win_idx;
            sel   <= win_idx;
            last  <= win_idx;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (grant_end) begin
            gnt <= 8'h00;
            cnt <= 4'd0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= 2'd0;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_cnt <= 2'd0;
          end else begin
            gap_cnt <= gap_cnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 8'h00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_8to1_rr_sched.sv
// Bench for mux_8to1_rr_sched: two instances (defaults, and HOLD=1/GAP=0)
// share stimulus; a grant-level model is compared on every falling edge,
// and directed scenarios pin the model with hand-computed literals.
module tb_mux_8to1_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt_a, gnt_b;
  logic       s0_a, s1_a, s2_a, busy_a;
  logic       s0_b, s1_b, s2_b, busy_b;

  int checks   = 0;
  int failures = 0;

  mux_8to1_rr_sched #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a), .s0(s0_a), .s1(s1_a), .s2(s2_a), .busy(busy_a)
  );

  mux_8to1_rr_sched #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_b), .s0(s0_b), .s1(s1_b), .s2(s2_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- grant-level model ----------------
  // phase: 0 idle, 1 granted, 2 turnaround
  int m_phase[2], m_owner[2], m_last[2], m_sel[2], m_used[2], m_gapleft[2];

  function automatic int hold_of(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic int gap_of(input int m);
    return (m == 0) ? 1 : 0;
  endfunction

  function automatic int pick_next(input int lst, input logic [7:0] r);
    int res = -1;
    for (int k = 1; k <= 8; k++) begin
      int idx = (lst + k) % 8;
      if (res < 0 && r[idx]) res = idx;
    end
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_phase[m] <= 0; m_owner[m] <= 0; m_last[m] <= 7;
        m_sel[m] <= 0; m_used[m] <= 0; m_gapleft[m] <= 0;
      end else if (m_phase[m] == 0) begin
        if (req != 8'h00) begin
          m_owner[m] <= pick_next(m_last[m], req);
          m_last[m]  <= pick_next(m_last[m], req);
          m_sel[m]   <= pick_next(m_last[m], req);
          m_used[m]  <= 1;
          m_phase[m] <= 1;
        end
      end else if (m_phase[m] == 1) begin
        if (done || !req[m_owner[m]] || m_used[m] == hold_of(m)) begin
          m_phase[m]   <= (gap_of(m) > 0) ? 2 : 0;
          m_gapleft[m] <= gap_of(m);
        end else begin
          m_used[m] <= m_used[m] + 1;
        end
      end else begin
        m_gapleft[m] <= m_gapleft[m] - 1;
        if (m_gapleft[m] == 1) m_phase[m] <= 0;
      end
    end
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    logic [7:0] eg;
    for (int m = 0; m < 2; m++) begin
      eg = (m_phase[m] == 1) ? (8'h01 << m_owner[m]) : 8'h00;
      if (m == 0) begin
        chk("model_gnt_a", {24'd0, gnt_a}, {24'd0, eg});
        chk("model_busy_a", {31'd0, busy_a}, (m_phase[0] != 0) ? 32'd1 : 32'd0);
        chk("model_sel_a", {29'd0, s2_a, s1_a, s0_a}, 32'(m_sel[0]));
      end else begin
        chk("model_gnt_b", {24'd0, gnt_b}, {24'd0, eg});
        chk("model_busy_b", {31'd0, busy_b}, (m_phase[1] != 0) ? 32'd1 : 32'd0);
        chk("model_sel_b", {29'd0, s2_b, s1_b, s0_b}, 32'(m_sel[1]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [7:0] v);
    int r = -1;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  int st_cyc[16], st_idx[16], st_sel[16], g_len[16];
  int nst;
  logic [7:0] prev;

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    chk("rst_gnt", {24'd0, gnt_a}, 32'h00);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_sel", {29'd0, s2_a, s1_a, s0_a}, 32'd0);

    // Reset asserted mid-grant
    rst = 1'b0; req = 8'h08;
    tick();
    chk("mid_gnt08", {24'd0, gnt_a}, 32'h08);
    tick();
    rst = 1'b1;
    #1;
    chk("async_gnt", {24'd0, gnt_a}, 32'h00);
    chk("async_busy", {31'd0, busy_a}, 32'd0);
    chk("async_sel", {29'd0, s2_a, s1_a, s0_a}, 32'd0);
    tick();
    rst = 1'b0; req = 8'h01;
    tick();
    chk("post_rst_gnt01", {24'd0, gnt_a}, 32'h01);

    // Round robin with all requesting
    do_reset();
    req = 8'hFF;
    nst = 0; prev = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (prev == 8'h00 && gnt_a != 8'h00 && nst < 16) begin
        st_cyc[nst] = c; st_idx[nst] = onehot_idx(gnt_a);
        st_sel[nst] = int'({s2_a, s1_a, s0_a}); g_len[nst] = 0;
        nst++;
      end
      if (gnt_a != 8'h00 && nst > 0) g_len[nst-1]++;
      prev = gnt_a;
    end
    chk("rr_count", (nst >= 9) ? 32'd1 : 32'd0, 32'd1);
    for (int j = 0; j < 9 && j < nst; j++) begin
      chk("rr_order", 32'(st_idx[j]), 32'(j % 8));
      chk("rr_sel", 32'(st_sel[j]), 32'(j % 8));
      chk("rr_len", 32'(g_len[j]), 32'd4);
      if (j > 0) chk("rr_spacing", 32'(st_cyc[j] - st_cyc[j-1]), 32'd6);
    end

    // Early release
    do_reset();
    req = 8'h24;
    tick();
    chk("er_gnt1", {24'd0, gnt_a}, 32'h04);
    tick();
    chk("er_gnt2", {24'd0, gnt_a}, 32'h04);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("er_gap_gnt", {24'd0, gnt_a}, 32'h00);
    chk("er_gap_busy", {31'd0, busy_a}, 32'd1);
    chk("er_gap_sel", {29'd0, s2_a, s1_a, s0_a}, 32'd2);
    tick();
    chk("er_idle_busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("er_next_gnt", {24'd0, gnt_a}, 32'h20);
    chk("er_next_sel", {29'd0, s2_a, s1_a, s0_a}, 32'd5);

    // Request drop, and done outside GRANT
    do_reset();
    req = 8'h40;
    tick();
    chk("rd_gnt", {24'd0, gnt_a}, 32'h40);
    req = 8'h00;
    tick();
    chk("rd_release", {24'd0, gnt_a}, 32'h00);
    chk("rd_gap_busy", {31'd0, busy_a}, 32'd1);
    req = 8'h40; done = 1'b1;
    tick();
    chk("rd_idle", {31'd0, busy_a}, 32'd0);
    tick();
    done = 1'b0;
    chk("rd_done_ignored", {24'd0, gnt_a}, 32'h40);
    tick();
    chk("rd_still_held", {24'd0, gnt_a}, 32'h40);

    // Parameter corner on instance B: HOLD=1, GAP=0
    do_reset();
    req = 8'h81;
    tick();
    chk("pc_gnt0", {24'd0, gnt_b}, 32'h01);
    chk("pc_busy0", {31'd0, busy_b}, 32'd1);
    tick();
    chk("pc_idle1", {24'd0, gnt_b}, 32'h00);
    chk("pc_busy1", {31'd0, busy_b}, 32'd0);
    tick();
    chk("pc_gnt7", {24'd0, gnt_b}, 32'h80);
    chk("pc_busy2", {31'd0, busy_b}, 32'd1);
    chk("pc_sel7", {29'd0, s2_b, s1_b, s0_b}, 32'd7);
    tick();
    chk("pc_busy3", {31'd0, busy_b}, 32'd0);
    chk("pc_sel_hold", {29'd0, s2_b, s1_b, s0_b}, 32'd7);
    tick();
    chk("pc_wrap0", {24'd0, gnt_b}, 32'h01);

    // Sole requester
    do_reset();
    req = 8'h10;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 4 || (c >= 7 && c <= 10) || c == 13) begin
        chk("sole_gnt", {24'd0, gnt_a}, 32'h10);
      end else begin
        chk("sole_off", {24'd0, gnt_a}, 32'h00);
        chk("sole_busy", {31'd0, busy_a}, (c == 5 || c == 11) ? 32'd1 : 32'd0);
      end
      chk("sole_sel", {29'd0, s2_a, s1_a, s0_a}, 32'd4);
    end

    req = 8'h00;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_8to1_rr_sched.md
# mux_8to1_rr_sched

Round-robin scheduler that shares one `mux_8to1` datapath among eight requesters. It arbitrates a `req[7:0]` vector and grants the mux to one requester at a time. While the grant is held, it drives the mux select lines `s2,s1,s0` to the grantee's index. A grant ends on early release, on request drop, or on a maximum hold time, and is followed by a configurable turnaround gap.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: maximum cycles a grant is held. Legal range 1..15.
- `GAP_CYCLES`, default 1: idle turnaround cycles after each grant, with selects frozen. Legal range 0..3.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  8  request vector; bit n requests mux input `in`.
- `done`  in  1  early release by the current grantee. Ignored outside GRANT.
- `gnt`  out  8  one-hot grant; all zero outside GRANT.
- `s0`  out  1  mux select bit 0, connects to `mux_8to1.s0`.
- `s1`  out  1  mux select bit 1.
- `s2`  out  1  mux select bit 2.
- `busy`  out  1  high in GRANT and GAP.

## Operation

- FSM states: IDLE, GRANT, GAP. All outputs are registered.
- Round-robin pointer `last[2:0]` holds the index of the most recent grantee.
- Search order is `last+1, last+2, … , last+8`, taken mod 8, so index 7 wraps to 0.
- **IDLE**
  - If `req` is nonzero: the first set bit in search order wins.
  - On the next edge: load the winner into `gnt` (one-hot), `{s2,s1,s0}` and `last`; clear hold counter `cnt`; go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT** ends at the current edge if any of these holds:
  - `done` = 1;
  - `req[last]` = 0;
  - `cnt == HOLD_CYCLES-1`.
- On GRANT end: clear `gnt`. Next state is GAP if `GAP_CYCLES > 0`, else IDLE.
- Otherwise GRANT continues and `cnt` increments. `cnt` is 4 bits and never exceeds `HOLD_CYCLES-1`.
- **GAP**
  - Counts `GAP_CYCLES` cycles, then returns to IDLE.
  - `gnt` = 0; `busy` = 1.
  - `{s2,s1,s0}` hold the last grantee's index. They do not glitch.
- `{s2,s1,s0}` change only when a new grant loads. In IDLE they keep their previous value.
- `s2` is the MSB: index 5 gives `s2=1, s1=0, s0=1`.

## Timing

- Reset values, applied asynchronously and immediately on `rst`:
  - state = IDLE;
  - `gnt` = 8'h00;
  - `s2,s1,s0` = 0,0,0;
  - `busy` = 0;
  - `last` = 7, so the first search starts at index 0;
  - `cnt` = 0.
- Reset asserted mid-grant: `gnt` drops in the same cycle, without waiting for a clock edge.
- Grant latency: `req` sampled in IDLE at edge k gives `gnt`, selects and `busy` valid after edge k, a latency of 1 cycle.
- Grant length: 1..`HOLD_CYCLES` cycles, measured as cycles with `gnt` nonzero.
- Grant-to-grant spacing for back-to-back requesters: grant length + `GAP_CYCLES` + 1 IDLE cycle.
- Simultaneous end conditions (`done`, request drop, hold expiry at the same edge): a single release. GAP is entered once.
- Requests that assert during GRANT or GAP are not seen until the next IDLE arbitration.
- Sole requester holding `req` high: it is re-granted after each GAP, with a fresh `HOLD_CYCLES` window each time.
- `req` all zero in IDLE: stay in IDLE; outputs unchanged.
- Fairness bound: a continuously requesting input is granted within 7 grants of any other input.

## Test plan

- **Reset:** assert `rst` mid-GRANT, with `gnt`=8'h08 → `gnt`=8'h00, `busy`=0, `{s2,s1,s0}`=000 immediately. After release with `req`=8'h01, `gnt`=8'h01 one cycle later.
- **Round robin:** `req`=8'hFF held, `done`=0, defaults → grants in order 0,1,…,7,0. Each grant lasts 4 cycles; 6 cycles between grant starts. `{s2,s1,s0}` track the index; the 0→7→0 wrap is checked.
- **Early release:** `req`=8'h24, `done` pulsed in the 2nd GRANT cycle of index 2 → `gnt`=8'h04 for 2 cycles. Then GAP for 1 cycle with selects=010, then IDLE. Index 5 is granted next with selects=101.
- **Request drop:** the grantee at index 6 deasserts `req[6]` in its 1st GRANT cycle → a 1-cycle grant, then release. `done` pulsed while in IDLE or GAP has no effect.
- **Parameter corners:** `HOLD_CYCLES`=1, `GAP_CYCLES`=0, `req`=8'h81 → alternating 1-cycle grants to 7 and 0, each separated by one IDLE cycle. `busy` pattern is 1,0,1,0.
- **Sole requester:** `req`=8'h10 held, defaults → repeated `gnt`=8'h10 for 4 cycles, then 1 GAP cycle, then 1 IDLE cycle. Selects stay at 100 throughout.
